// File: rtl/qspi_flash_sequencer_if.sv
// Command bus between the flash sequencer and the QSPI memory controller.
// The sequencer drives the command side; the controller returns status.
interface qspi_flash_sequencer_if #(
    parameter int PAGE_BYTES = 256
);
    logic                        trigger;
    logic                        quad;
    logic [7:0]                  cmd;
    logic [(3+PAGE_BYTES)*8-1:0] data_send;
    logic [7:0]                  readout;
    logic                        busy;
    logic                        error;

    modport master (
        output trigger, quad, cmd, data_send,
        input  readout, busy, error
    );

    modport slave (
        input  trigger, quad, cmd, data_send,
        output readout, busy, error
    );
endinterface

// File: rtl/qspi_flash_sequencer.sv
// Flash program/verify sequencer: ID check, quad enable, erase,
// page program and byte-wise readback verify through the QSPI controller.
`ifndef CMD_RDID
`define CMD_RDID   8'h9F
`endif
`ifndef CMD_WRVECR
`define CMD_WRVECR 8'h61
`endif
`ifndef CMD_WREN
`define CMD_WREN   8'h06
`endif
`ifndef CMD_SSE
`define CMD_SSE    8'h20
`endif
`ifndef CMD_PP
`define CMD_PP     8'h02
`endif
`ifndef CMD_RDSR
`define CMD_RDSR   8'h05
`endif
`ifndef CMD_READ
`define CMD_READ   8'h03
`endif
`ifndef JEDEC_ID
`define JEDEC_ID   8'h20
`endif

module qspi_flash_sequencer #(
    parameter int          PAGE_BYTES  = 256,
    parameter int          NUM_PAGES   = 4,
    parameter logic [23:0] START_ADDR  = 24'hA30000,
    parameter logic [7:0]  SEED        = 8'hA5,
    parameter int          STARTUP_DLY = 10000,
    parameter int          POLL_LIMIT  = 200000,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    qspi_flash_sequencer_if.master        ctl,
    output logic                          done,
    output logic                          pass,
    output logic [2:0]                    fail_code,
    output logic [23:0]                   fail_addr,
    output logic [1:0]                    led
);
    localparam int DW    = (3 + PAGE_BYTES) * 8;
    localparam int TOTAL = NUM_PAGES * PAGE_BYTES;
    localparam int DLW   = $clog2(STARTUP_DLY + 2);
    localparam int PLW   = $clog2(POLL_LIMIT + 2);
    localparam int PGW   = $clog2(NUM_PAGES + 2);
    localparam int VW    = $clog2(TOTAL + 2);

    localparam logic [DLW-1:0] DLY       = DLW'(STARTUP_DLY);
    localparam logic [PLW-1:0] POLL_LAST = PLW'(POLL_LIMIT - 1);
    localparam logic [PGW-1:0] PAGE_LAST = PGW'(NUM_PAGES - 1);
    localparam logic [VW-1:0]  BYTE_LAST = VW'(TOTAL - 1);
    localparam logic [23:0]    PAGE_STEP = 24'(PAGE_BYTES);

    typedef enum logic [2:0] {
        WAIT_START, IDLE, ISSUE, SETTLE, WAIT_CMD, DONE_S, FAIL_S
    } state_t;

    typedef enum logic [2:0] {
        RDID, WRVECR, WREN_E, SSE, WREN_P, PP, POLL, READ
    } step_t;

    state_t           state, state_nx;
    step_t            step, step_nx;
    logic [DLW-1:0]   dly_cnt, dly_nx;
    logic [PLW-1:0]   poll_cnt, poll_nx;
    logic [PGW-1:0]   page, page_nx;
    logic [VW-1:0]    vcnt, vcnt_nx;
    logic [23:0]      paddr, paddr_nx, raddr, raddr_nx, next_paddr;
    logic             quad_r, quad_nx, pp_phase, pphase_nx;
    logic             done_nx, pass_nx;
    logic [2:0]       code_nx;
    logic [23:0]      faddr_nx;
    logic [7:0]       cmd_w;
    logic [DW-1:0]    data_w;
    logic [PAGE_BYTES*8-1:0] payload;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= WAIT_START;
            step      <= RDID;
            dly_cnt   <= '0;
            poll_cnt  <= '0;
            page      <= '0;
            vcnt      <= '0;
            paddr     <= '0;
            raddr     <= '0;
            quad_r    <= 1'b0;
            pp_phase  <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= '0;
            fail_addr <= '0;
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            dly_cnt   <= dly_nx;
            poll_cnt  <= poll_nx;
            page      <= page_nx;
            vcnt      <= vcnt_nx;
            paddr     <= paddr_nx;
            raddr     <= raddr_nx;
            quad_r    <= quad_nx;
            pp_phase  <= pphase_nx;
            done      <= done_nx;
            pass      <= pass_nx;
            fail_code <= code_nx;
            fail_addr <= faddr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        step_nx    = step;
        dly_nx     = dly_cnt;
        poll_nx    = poll_cnt;
        page_nx    = page;
        vcnt_nx    = vcnt;
        paddr_nx   = paddr;
        raddr_nx   = raddr;
        quad_nx    = quad_r;
        pphase_nx  = pp_phase;
        done_nx    = done;
        pass_nx    = pass;
        code_nx    = fail_code;
        faddr_nx   = fail_addr;
        next_paddr = paddr + PAGE_STEP;
        unique case (state)
            WAIT_START: begin
                if (dly_cnt == DLY) state_nx = AUTO_START ? ISSUE : IDLE;
                else if (!ctl.busy) dly_nx = dly_cnt + 1'b1;
            end
            IDLE, DONE_S, FAIL_S: begin
                if (start) begin
                    state_nx = ISSUE;
                    step_nx  = RDID;
                    quad_nx  = 1'b0;
                    done_nx  = 1'b0;
                    pass_nx  = 1'b0;
                    code_nx  = '0;
                    faddr_nx = '0;
                end
            end
            ISSUE:  state_nx = SETTLE;
            SETTLE: state_nx = WAIT_CMD;
            WAIT_CMD: begin
                if (!ctl.busy) begin
                    state_nx = ISSUE;
                    if (ctl.error) begin
                        state_nx = FAIL_S;
                        done_nx  = 1'b1;
                        code_nx  = 3'd2;
                    end else begin
                        unique case (step)
                            RDID: begin
                                if (ctl.readout != `JEDEC_ID) begin
                                    state_nx = FAIL_S;
                                    done_nx  = 1'b1;
                                    code_nx  = 3'd1;
                                end else step_nx = WRVECR;
                            end
                            WRVECR: begin
                                quad_nx  = 1'b1;
                                page_nx  = '0;
                                paddr_nx = START_ADDR;
                                step_nx  = WREN_E;
                            end
                            WREN_E: step_nx = SSE;
                            WREN_P: step_nx = PP;
                            SSE, PP: begin
                                step_nx   = POLL;
                                pphase_nx = (step == PP);
                                poll_nx   = '0;
                            end
                            POLL: begin
                                if (!ctl.readout[0]) begin
                                    if (!pp_phase) step_nx = WREN_P;
                                    else if (page == PAGE_LAST) begin
                                        step_nx  = READ;
                                        raddr_nx = START_ADDR;
                                        vcnt_nx  = '0;
                                    end else begin
                                        page_nx  = page + 1'b1;
                                        paddr_nx = next_paddr;
                                        // each new 4 KB subsector is erased before its first page
                                        step_nx  = (next_paddr[11:0] == 12'h000) ? WREN_E : WREN_P;
                                    end
                                end else if (poll_cnt == POLL_LAST) begin
                                    state_nx = FAIL_S;
                                    done_nx  = 1'b1;
                                    code_nx  = 3'd3;
                                end else poll_nx = poll_cnt + 1'b1;
                            end
                            READ: begin
                                if (ctl.readout != (raddr[7:0] ^ SEED)) begin
                                    state_nx = FAIL_S;
                                    done_nx  = 1'b1;
                                    code_nx  = 3'd4;
                                    faddr_nx = raddr;
                                end else if (vcnt == BYTE_LAST) begin
                                    state_nx = DONE_S;
                                    done_nx  = 1'b1;
                                    pass_nx  = 1'b1;
                                end else begin
                                    raddr_nx = raddr + 24'd1;
                                    vcnt_nx  = vcnt + 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            default: state_nx = WAIT_START;
        endcase
    end

    always_comb begin
        payload = '0;
        for (int i = 0; i < PAGE_BYTES; i++)
            payload[(PAGE_BYTES-1-i)*8 +: 8] = (paddr[7:0] + 8'(i)) ^ SEED;
    end

    always_comb begin
        cmd_w  = 8'h00;
        data_w = '0;
        if (state inside {ISSUE, SETTLE, WAIT_CMD}) begin
            unique case (1'b1)
                step == RDID:   cmd_w = `CMD_RDID;
                step == WRVECR: begin
                    cmd_w       = `CMD_WRVECR;
                    data_w[7:0] = 8'b010_01_111;
                end
                step inside {WREN_E, WREN_P}: cmd_w = `CMD_WREN;
                step == SSE: begin
                    cmd_w              = `CMD_SSE;
                    data_w[DW-1 -: 24] = paddr;
                end
                step == PP: begin
                    cmd_w  = `CMD_PP;
                    data_w = {paddr, payload};
                end
                step == POLL: cmd_w = `CMD_RDSR;
                step == READ: begin
                    cmd_w              = `CMD_READ;
                    data_w[DW-1 -: 24] = raddr;
                end
                default: cmd_w = 8'h00;
            endcase
        end
    end

    assign ctl.trigger   = (state == ISSUE);
    assign ctl.quad      = quad_r;
    assign ctl.cmd       = cmd_w;
    assign ctl.data_send = data_w;
    assign led           = {pass, done};
endmodule

// File: tb/tb_qspi_flash_sequencer.sv
// Directed bench for qspi_flash_sequencer with a behavioural flash/controller model.
// 64-byte pages from A30F00 so the run crosses one 4 KB subsector boundary.
module tb_qspi_flash_sequencer;
    localparam int          PB   = 64;
    localparam int          NP   = 20;
    localparam logic [23:0] SA   = 24'hA30F00;
    localparam int          DW   = (3 + PB) * 8;

    logic        clk = 1'b0;
    logic        reset_n, start, clr;
    logic        done, pass;
    logic [2:0]  fail_code;
    logic [23:0] fail_addr;
    logic [1:0]  led;

    logic [7:0]  id_val, err_cmd;
    logic        stuck, corrupt;
    logic [23:0] caddr;

    int nchk = 0;
    int nfail = 0;

    qspi_flash_sequencer_if #(.PAGE_BYTES(PB)) bus ();

    qspi_flash_sequencer #(
        .PAGE_BYTES(PB), .NUM_PAGES(NP), .START_ADDR(SA), .SEED(8'hA5),
        .STARTUP_DLY(20), .POLL_LIMIT(16), .AUTO_START(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ctl(bus),
        .done(done), .pass(pass), .fail_code(fail_code),
        .fail_addr(fail_addr), .led(led)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:8191];
    logic [23:0] sse_log [0:7];
    logic [7:0]  mcmd, mread;
    logic [1:0]  mcnt;
    logic [3:0]  wip;
    logic        wel;
    logic [23:0] ta;
    int rdid_n, wrv_n, pp_n, read_n, rdsr_n, sse_n, bad, cyc, first_trig;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.busy <= 1'b0; bus.error <= 1'b0; bus.readout <= 8'h00;
            mcnt <= '0; wip <= '0; wel <= 1'b0; mcmd <= 8'h00; mread <= 8'h00;
            rdid_n <= 0; wrv_n <= 0; pp_n <= 0; read_n <= 0; rdsr_n <= 0;
            sse_n <= 0; bad <= 0; cyc <= 0; first_trig <= -1;
        end else begin
            cyc <= cyc + 1;
            if (bus.trigger) begin
                ta = bus.data_send[DW-1 -: 24];
                if (first_trig < 0) first_trig <= cyc;
                bus.busy <= 1'b1; bus.error <= 1'b0; mcnt <= 2'd2; mcmd <= bus.cmd;
                case (bus.cmd)
                    8'h9F: begin
                        mread <= id_val; rdid_n <= rdid_n + 1;
                        if (bus.quad) bad <= bad + 1;
                    end
                    8'h61: begin
                        wrv_n <= wrv_n + 1;
                        if (bus.data_send[7:0] != 8'h4F) bad <= bad + 1;
                    end
                    8'h06: wel <= 1'b1;
                    8'h20: begin
                        if (!wel) bad <= bad + 1;
                        wel <= 1'b0; wip <= 4'd3;
                        for (int i = 0; i < 4096; i++) mem[{ta[12], 12'(i)}] <= 8'hFF;
                        if (sse_n < 8) sse_log[sse_n[2:0]] <= ta;
                        sse_n <= sse_n + 1;
                    end
                    8'h02: begin
                        if (!wel) bad <= bad + 1;
                        wel <= 1'b0; wip <= 4'd3; pp_n <= pp_n + 1;
                        for (int i = 0; i < PB; i++)
                            mem[13'(ta[12:0] + 13'(i))] <= mem[13'(ta[12:0] + 13'(i))]
                                & bus.data_send[(PB-1-i)*8 +: 8];
                    end
                    8'h05: begin
                        mread <= {7'b0, stuck | (wip != 0)};
                        if (wip != 0) wip <= wip - 1'b1;
                        rdsr_n <= rdsr_n + 1;
                    end
                    8'h03: begin
                        mread <= mem[ta[12:0]] ^ ((corrupt && ta == caddr) ? 8'h01 : 8'h00);
                        read_n <= read_n + 1;
                    end
                    default: bad <= bad + 1;
                endcase
            end else if (mcnt != 0) begin
                mcnt <= mcnt - 1'b1;
                if (mcnt == 2'd1) begin
                    bus.busy <= 1'b0; bus.readout <= mread; bus.error <= (mcmd == err_cmd);
                end
            end
            if (clr) begin
                rdid_n <= 0; wrv_n <= 0; pp_n <= 0; read_n <= 0; rdsr_n <= 0;
                sse_n <= 0; bad <= 0;
            end
        end
    end

    task automatic clear_model();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        nchk++; if ({done, pass, fail_code, fail_addr, led} !== 31'd0) begin
            nfail++; $display("FAIL reset_status: got %0h expected 0", {done, pass, fail_code, fail_addr, led});
        end
        nchk++; if ({bus.trigger, bus.quad, bus.cmd} !== 10'd0 || bus.data_send !== '0) begin
            nfail++; $display("FAIL reset_bus: got trig %0b quad %0b cmd %0h expected all 0", bus.trigger, bus.quad, bus.cmd);
        end
    endtask

    task automatic test_auto_run();
        bit ok;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_done(20000, ok);
        nchk++; if (!ok) begin nfail++; $display("FAIL auto_timeout: done got 0 expected 1"); end
        nchk++; if (first_trig < 20) begin nfail++; $display("FAIL auto_startup: first trigger cycle %0d expected >= 20", first_trig); end
        nchk++; if ({pass, fail_code, led} !== 6'b1_000_11) begin
            nfail++; $display("FAIL auto_status: got pass %0b code %0d led %0b expected 1 0 11", pass, fail_code, led);
        end
        nchk++; if (pp_n !== 20 || read_n !== 1280 || wrv_n !== 1) begin
            nfail++; $display("FAIL auto_counts: got pp %0d rd %0d wrv %0d expected 20 1280 1", pp_n, read_n, wrv_n);
        end
        nchk++; if (sse_n !== 2 || sse_log[0] !== 24'hA30F00 || sse_log[1] !== 24'hA31000) begin
            nfail++; $display("FAIL auto_sse: got n %0d %0h %0h expected 2 a30f00 a31000", sse_n, sse_log[0], sse_log[1]);
        end
        nchk++; if (bad !== 0 || bus.quad !== 1'b1) begin
            nfail++; $display("FAIL auto_proto: got bad %0d quad %0b expected 0 1", bad, bus.quad);
        end
    endtask

    task automatic test_corrupt();
        bit ok;
        clear_model();
        corrupt = 1'b1; caddr = 24'hA31105;
        pulse_start();
        wait_done(20000, ok);
        corrupt = 1'b0;
        nchk++; if (!ok) begin nfail++; $display("FAIL corrupt_timeout: done got 0 expected 1"); end
        nchk++; if ({pass, fail_code, led} !== 6'b0_100_01 || fail_addr !== 24'hA31105) begin
            nfail++; $display("FAIL corrupt_status: got pass %0b code %0d addr %0h expected 0 4 a31105", pass, fail_code, fail_addr);
        end
        nchk++; if (read_n !== 518) begin nfail++; $display("FAIL corrupt_reads: got %0d expected 518", read_n); end
    endtask

    task automatic test_id_mismatch();
        bit ok;
        clear_model();
        id_val = 8'h00;
        pulse_start();
        wait_done(200, ok);
        id_val = 8'h20;
        nchk++; if (!ok || pass !== 1'b0 || fail_code !== 3'd1 || fail_addr !== 24'd0) begin
            nfail++; $display("FAIL id_status: got done %0b pass %0b code %0d addr %0h expected 1 0 1 0", ok, pass, fail_code, fail_addr);
        end
        nchk++; if (wrv_n !== 0 || pp_n !== 0 || rdid_n !== 1) begin
            nfail++; $display("FAIL id_counts: got wrv %0d pp %0d rdid %0d expected 0 0 1", wrv_n, pp_n, rdid_n);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_model();
        pulse_start();
        nchk++; if (done !== 1'b0 || fail_code !== 3'd0 || bus.quad !== 1'b0 || bus.cmd !== 8'h9F) begin
            nfail++; $display("FAIL restart_clear: got done %0b code %0d quad %0b cmd %0h expected 0 0 0 9f", done, fail_code, bus.quad, bus.cmd);
        end
        repeat (150) @(negedge clk);
        pulse_start();
        wait_done(20000, ok);
        nchk++; if (!ok || pass !== 1'b1 || rdid_n !== 1 || pp_n !== 20 || read_n !== 1280) begin
            nfail++; $display("FAIL ignore_start: got pass %0b rdid %0d pp %0d rd %0d expected 1 1 20 1280", pass, rdid_n, pp_n, read_n);
        end
    endtask

    task automatic test_poll_timeout();
        bit ok;
        clear_model();
        stuck = 1'b1;
        pulse_start();
        wait_done(500, ok);
        stuck = 1'b0;
        nchk++; if (!ok || fail_code !== 3'd3 || pass !== 1'b0) begin
            nfail++; $display("FAIL poll_status: got done %0b code %0d expected 1 3", ok, fail_code);
        end
        nchk++; if (rdsr_n !== 16 || pp_n !== 0 || sse_n !== 1) begin
            nfail++; $display("FAIL poll_counts: got rdsr %0d pp %0d sse %0d expected 16 0 1", rdsr_n, pp_n, sse_n);
        end
    endtask

    task automatic test_ctrl_error();
        bit ok;
        clear_model();
        err_cmd = 8'h02;
        pulse_start();
        wait_done(500, ok);
        err_cmd = 8'hFF;
        nchk++; if (!ok || fail_code !== 3'd2 || pp_n !== 1 || fail_addr !== 24'd0) begin
            nfail++; $display("FAIL err_status: got done %0b code %0d pp %0d addr %0h expected 1 2 1 0", ok, fail_code, pp_n, fail_addr);
        end
    endtask

    task automatic test_reset_mid_pp();
        bit ok, hit;
        clear_model();
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pp_n == 2 && bus.busy && mcmd == 8'h02) begin hit = 1'b1; break; end
        end
        nchk++; if (!hit) begin nfail++; $display("FAIL rst_reach_pp: got 0 expected PP in flight"); end
        reset_n = 1'b0;
        #1;
        nchk++; if ({done, pass, fail_code, fail_addr, led, bus.trigger, bus.quad, bus.cmd} !== 41'd0 || bus.data_send !== '0) begin
            nfail++; $display("FAIL rst_outputs: got cmd %0h quad %0b done %0b expected all 0", bus.cmd, bus.quad, done);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_done(20000, ok);
        nchk++; if (!ok || pass !== 1'b1 || pp_n !== 20 || read_n !== 1280 || sse_n !== 2 || bad !== 0) begin
            nfail++; $display("FAIL rst_rerun: got pass %0b pp %0d rd %0d sse %0d bad %0d expected 1 20 1280 2 0", pass, pp_n, read_n, sse_n, bad);
        end
    endtask

    initial begin
        start = 1'b0; clr = 1'b0; id_val = 8'h20; err_cmd = 8'hFF;
        stuck = 1'b0; corrupt = 1'b0; caddr = 24'd0;
        test_reset();
        test_auto_run();
        test_corrupt();
        test_id_mismatch();
        test_back_to_back();
        test_poll_timeout();
        test_ctrl_error();
        test_reset_mid_pp();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
